// File: rtl/twiddle_seq.sv
// twiddle_seq: walks a cosine ROM to produce one (cos, sin) twiddle pair per bin.
// Each bin takes two ROM reads: one at address k for the cosine, and one at
// k + 3N/4 for the sine, using sin(x) = cos(x - pi/2).
// Optional build macro TWIDDLE_SEQ_CONJ_EN negates the sine output, with
// saturation, to give the conjugate twiddle.
module twiddle_seq #(
    parameter int N_BINS = 512,
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    output logic                     ready_o,
    output logic [AWIDTH-1:0]        rom_addr_o,
    input  logic signed [DWIDTH-1:0] rom_data_i,
    output logic [AWIDTH-1:0]        k_o,
    output logic signed [DWIDTH-1:0] cos_o,
    output logic signed [DWIDTH-1:0] sin_o,
    output logic                     valid_o,
    output logic                     last_o,
    output logic                     overrun_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // A quarter turn back is three quarters forward, modulo N_BINS.
    localparam logic [AWIDTH-1:0] SIN_OFS = AWIDTH'(3 * N_BINS / 4);
    localparam logic [AWIDTH-1:0] K_LAST  = AWIDTH'(N_BINS - 1);

    logic [1:0]               r_state;
    logic [AWIDTH-1:0]        r_k;
    logic                     r_phase;      // 0: cos read, 1: sin read
    logic                     r_drain;

    logic                     r_cos_p1;     // ROM data this cycle is a cosine
    logic                     r_sin_p1;     // ROM data this cycle is a sine
    logic [AWIDTH-1:0]        r_k_p1;
    logic signed [DWIDTH-1:0] r_cos_p1_data;

    logic [AWIDTH-1:0]        r_k_o;
    logic signed [DWIDTH-1:0] r_cos_o;
    logic signed [DWIDTH-1:0] r_sin_o;
    logic                     r_valid;
    logic                     r_last;
    logic                     r_overrun;

    logic                     w_run;
    logic                     w_cos_ph;
    logic                     w_sin_ph;
    logic [AWIDTH-1:0]        w_sin_addr;
    logic signed [DWIDTH-1:0] w_sin_val;

`ifdef TWIDDLE_SEQ_CONJ_EN
    localparam logic signed [DWIDTH-1:0] D_MIN = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic signed [DWIDTH-1:0] D_MAX = {1'b0, {(DWIDTH-1){1'b1}}};

    // Negation that clamps the one unrepresentable case instead of wrapping.
    function automatic logic signed [DWIDTH-1:0] neg_sat(input logic signed [DWIDTH-1:0] x);
        if (x == D_MIN) begin
            return D_MAX;
        end
        return -x;
    endfunction

    assign w_sin_val = neg_sat(rom_data_i);
`else
    assign w_sin_val = rom_data_i;
`endif

    assign w_run      = (r_state == S_RUN);
    assign w_cos_ph   = w_run && !r_phase;
    assign w_sin_ph   = w_run && r_phase;
    assign w_sin_addr = r_k + SIN_OFS;   // carry out is dropped: modulo N_BINS

    assign ready_o    = (r_state == S_IDLE);
    assign rom_addr_o = !w_run ? '0 : (r_phase ? w_sin_addr : r_k);
    assign k_o        = r_k_o;
    assign cos_o      = r_cos_o;
    assign sin_o      = r_sin_o;
    assign valid_o    = r_valid;
    assign last_o     = r_last;
    assign overrun_o  = r_overrun;

    // Sweep control: IDLE -> RUN (two reads per bin) -> DRAIN (two cycles) -> IDLE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_phase <= 1'b0;
            r_drain <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_RUN;
                        r_k     <= '0;
                        r_phase <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_k <= r_k + 1'b1;   // wraps to 0 after the last bin
                        if (r_k == K_LAST) begin
                            r_state <= S_DRAIN;
                            r_drain <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ROM return path: tag each returning word, hold the cosine until its sine arrives.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cos_p1      <= 1'b0;
            r_sin_p1      <= 1'b0;
            r_k_p1        <= '0;
            r_cos_p1_data <= '0;
        end else begin
            r_cos_p1 <= w_cos_ph;
            r_sin_p1 <= w_sin_ph;
            if (w_sin_ph) begin
                r_k_p1 <= r_k;
            end
            if (r_cos_p1) begin
                r_cos_p1_data <= rom_data_i;
            end
        end
    end

    // Output register: publish a complete pair once the sine word has arrived.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_k_o   <= '0;
            r_cos_o <= '0;
            r_sin_o <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= r_sin_p1;
            r_last  <= r_sin_p1 && (r_k_p1 == K_LAST);
            if (r_sin_p1) begin
                r_k_o   <= r_k_p1;
                r_cos_o <= r_cos_p1_data;
                r_sin_o <= w_sin_val;
            end
        end
    end

    // Flag a start request that arrives while a sweep is still in progress.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= start_i && (r_state != S_IDLE);
        end
    end

endmodule

// File: doc/twiddle_seq.md
TWIDDLE_SEQ -- requirements
Module: twiddle_seq

Interface
REQ-001 SHALL have parameter N_BINS, default 512: bins per sweep and ROM depth; power of two, at least 4.
REQ-002 SHALL have parameter AWIDTH, default 9: address width, equal to log2(N_BINS).
REQ-003 SHALL have parameter DWIDTH, default 16: signed two's-complement twiddle width.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port rst_n_i, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1: request one full bin sweep.
REQ-007 SHALL have port ready_o, output, 1: idle, so start_i is accepted.
REQ-008 SHALL have port rom_addr_o, output, AWIDTH: address to the cosine ROM. The ROM holds cos(2*pi*a/N_BINS) and returns data one cycle after the address.
REQ-009 SHALL have port rom_data_i, input, DWIDTH: ROM read data.
REQ-010 SHALL have port k_o, output, AWIDTH: bin index of the current output.
REQ-011 SHALL have port cos_o, output, DWIDTH: twiddle real part.
REQ-012 SHALL have port sin_o, output, DWIDTH: twiddle imaginary part.
REQ-013 SHALL have port valid_o, output, 1: k_o, cos_o and sin_o are valid this cycle.
REQ-014 SHALL have port last_o, output, 1: qualifies valid_o for k = N_BINS-1.
REQ-015 SHALL have port overrun_o, output, 1: one-cycle pulse when start_i arrives while busy.

Function
REQ-016 SHALL have states IDLE, RUN and DRAIN; ready_o = (state == IDLE).
REQ-017 IDLE -> RUN SHALL occur on start_i while in IDLE; the cycle start_i is sampled is cycle 0.
REQ-018 In RUN, each bin k SHALL use two cycles:
  - cycle 1+2k: rom_addr_o = k (cos phase).
  - cycle 2+2k: rom_addr_o = (k + 3*N_BINS/4) mod N_BINS (sin phase). This uses sin(x) = cos(x - pi/2).
REQ-019 RUN -> DRAIN SHALL occur after the sin-phase address of k = N_BINS-1 (cycle 2*N_BINS).
REQ-020 DRAIN SHALL last exactly 2 cycles, then the block SHALL return to IDLE; ready_o is high again at cycle 2*N_BINS+3.
REQ-021 Capture and output for bin k:
  - cos SHALL be captured from rom_data_i in cycle 2+2k.
  - sin SHALL be captured from rom_data_i in cycle 3+2k.
  - valid_o SHALL be high for exactly one cycle, at cycle 4+2k.
  - k_o, cos_o and sin_o SHALL be registered and held until the next valid_o.
REQ-022 valid_o SHALL pulse exactly N_BINS times per sweep, every second cycle, with k_o = 0..N_BINS-1 in order.
REQ-023 last_o SHALL be high only together with the valid_o for k = N_BINS-1.
REQ-024 rom_addr_o SHALL be 0 whenever the state is not RUN.
REQ-025 The bin counter SHALL wrap to 0 at the end of a sweep; the sin address SHALL wrap modulo N_BINS with no carry out.
REQ-026 start_i outside IDLE SHALL be ignored, SHALL raise overrun_o for one cycle, and SHALL NOT disturb the sweep in progress.
REQ-027 start_i in the same cycle that DRAIN -> IDLE occurs SHALL be treated as busy (ignored, overrun_o = 1).
REQ-028 There SHALL be no backpressure; the consumer must accept every valid_o.

Reset
REQ-029 When rst_n_i is low, the block SHALL immediately enter IDLE and clear the counters.
REQ-030 While rst_n_i is low, outputs SHALL be: ready_o = 1; valid_o, last_o and overrun_o = 0; rom_addr_o, k_o, cos_o and sin_o = 0.
REQ-031 A reset mid-sweep SHALL abort the sweep with no further valid_o; a new start_i is accepted from the first cycle after reset release.

Configuration
REQ-032 Macro TWIDDLE_SEQ_CONJ_EN SHALL select the sign of the imaginary part:
  - Defined: sin_o = -sin, giving the conjugate twiddle e^(-j*2*pi*k/N) used by the forward DFT. Negating the most negative value SHALL saturate to the most positive value (-32768 -> 32767 at DWIDTH = 16).
  - Undefined: sin_o = sin unmodified, and no saturation logic is present.
  - Timing SHALL be identical in both builds.

Verification (N_BINS = 8, ROM[a] = round(32767*cos(2*pi*a/8)) = 32767, 23170, 0, -23170, -32767, -23170, 0, 23170)
REQ-033 Single sweep, macro undefined: start_i at cycle 0 -> the following SHALL all be observed:
  - rom_addr_o sequence 0,6,1,7,2,0,3,1,4,2,5,3,6,4,7,5 over cycles 1..16.
  - valid_o at cycles 4,6,...,18.
  - k = 2 gives cos_o = 0, sin_o = 32767.
  - last_o only at cycle 18.
  - ready_o high at cycle 19.
REQ-034 Macro defined: same stimulus -> k = 2 gives sin_o = -32767, and k = 6 gives sin_o = 32767.
REQ-035 Saturation: macro defined, ROM[0] forced to -32768 -> at k = 2, sin_o = 32767 (no wrap to -32768).
REQ-036 Overrun: start_i at cycles 0 and 5 -> overrun_o pulses at cycle 6 only, and the sweep output is identical to REQ-033.
REQ-037 Reset mid-sweep: rst_n_i low at cycle 9 -> all outputs are 0 and ready_o = 1 at once; no further valid_o; start_i one cycle after release produces a full correct sweep.
REQ-038 Back-to-back: start_i held high continuously -> sweeps restart at cycle 19, 38, ... with no dropped or duplicated k.
